// File: rtl/ram2_arbiter_pkg.sv
// Shared types and defaults for the RAM2 SRAM arbiter.
// Holds the FSM encoding, requester IDs and strobe timing defaults.
package ram2_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_WR_SETUP,
      ST_WR_PULSE,
      ST_WR_HOLD,
      ST_DONE
   } state_t;

   typedef enum logic {
      OWN_IF  = 1'b0,
      OWN_MEM = 1'b1
   } owner_t;

   localparam int RD_CYCLES_DEF = 1;
   localparam int WE_CYCLES_DEF = 2;

   typedef struct packed {
      owner_t      owner;
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
   } access_t;

   // The timer counts down to zero, so an N-cycle phase loads N-1.
   function automatic logic [2:0] cnt_load(input int cycles);
      return 3'(cycles - 1);
   endfunction

endpackage

// File: rtl/ram2_arb_timer.sv
// Loadable 3-bit down-counter timing the OE and WE low phases.
module ram2_arb_timer
   import ram2_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       dec,
   input  logic [2:0] load_val,
   output logic       zero
);

   logic [2:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && cnt != 3'd0) begin
         cnt <= cnt - 3'd1;
      end
   end

   assign zero = (cnt == 3'd0);

endmodule

// File: rtl/ram2_arbiter.sv
// RAM2 SRAM sequencer shared by instruction fetch and the memory stage.
// MEM has fixed priority; all SRAM strobes and the data bus are registered.
module ram2_arbiter
   import ram2_arbiter_pkg::*;
#(
   parameter int RD_CYCLES = RD_CYCLES_DEF,
   parameter int WE_CYCLES = WE_CYCLES_DEF
) (
   input  logic        arbi_clk,
   input  logic        arbi_rst,
   input  logic        arbi_if_req,
   input  logic [15:0] arbi_if_addr,
   output logic [15:0] arbo_if_data,
   output logic        arbo_if_valid,
   output logic        arbo_if_stall,
   input  logic        arbi_mem_req,
   input  logic        arbi_mem_we,
   input  logic [15:0] arbi_mem_addr,
   input  logic [15:0] arbi_mem_wdata,
   output logic [15:0] arbo_mem_rdata,
   output logic        arbo_mem_done,
   output logic        arbo_mem_stall,
   output logic        arbo_ram2_en,
   output logic        arbo_ram2_oe,
   output logic        arbo_ram2_we,
   output logic [15:0] arbo_ram2_addr,
   inout  wire  [15:0] arbio_ram2_data
);

   localparam logic [2:0] RD_LOAD = cnt_load(RD_CYCLES);
   localparam logic [2:0] WE_LOAD = cnt_load(WE_CYCLES);

   state_t      state;
   state_t      nxt;
   access_t     cur;
   access_t     win;
   logic        grant;
   logic        capture;
   logic        t_load;
   logic        t_dec;
   logic        t_zero;
   logic [2:0]  t_val;
   logic        drive;

   ram2_arb_timer u_timer (
      .clk      (arbi_clk),
      .rst      (arbi_rst),
      .load     (t_load),
      .dec      (t_dec),
      .load_val (t_val),
      .zero     (t_zero)
   );

   always_ff @(posedge arbi_clk) begin
      if (arbi_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= nxt;
      end
   end

   always_comb begin
      nxt       = state;
      grant     = 1'b0;
      capture   = 1'b0;
      t_load    = 1'b0;
      t_dec     = 1'b0;
      t_val     = RD_LOAD;
      win.owner = OWN_IF;
      win.we    = 1'b0;
      win.addr  = arbi_if_addr;
      win.wdata = arbi_mem_wdata;
      if (arbi_mem_req) begin
         win.owner = OWN_MEM;
         win.we    = arbi_mem_we;
         win.addr  = arbi_mem_addr;
      end
      unique case (state)
         ST_IDLE: begin
            if (arbi_mem_req || arbi_if_req) begin
               grant = 1'b1;
               if (win.we) begin
                  nxt = ST_WR_SETUP;
               end else begin
                  nxt    = ST_RD;
                  t_load = 1'b1;
                  t_val  = RD_LOAD;
               end
            end
         end
         ST_RD: begin
            if (t_zero) begin
               nxt     = ST_DONE;
               capture = 1'b1;
            end else begin
               t_dec = 1'b1;
            end
         end
         ST_WR_SETUP: begin
            nxt    = ST_WR_PULSE;
            t_load = 1'b1;
            t_val  = WE_LOAD;
         end
         ST_WR_PULSE: begin
            if (t_zero) begin
               nxt = ST_WR_HOLD;
            end else begin
               t_dec = 1'b1;
            end
         end
         ST_WR_HOLD: nxt = ST_DONE;
         ST_DONE:    nxt = ST_IDLE;
         default:    nxt = ST_IDLE;
      endcase
   end

   // Strobes are derived from the next state so they toggle with it.
   always_ff @(posedge arbi_clk) begin
      if (arbi_rst) begin
         arbo_ram2_en   <= 1'b1;
         arbo_ram2_oe   <= 1'b1;
         arbo_ram2_we   <= 1'b1;
         arbo_ram2_addr <= '0;
         drive          <= 1'b0;
         cur            <= '0;
         arbo_if_data   <= '0;
         arbo_mem_rdata <= '0;
         arbo_if_valid  <= 1'b0;
         arbo_mem_done  <= 1'b0;
      end else begin
         arbo_ram2_en  <= 1'b0;
         arbo_ram2_oe  <= (nxt != ST_RD);
         arbo_ram2_we  <= (nxt != ST_WR_PULSE);
         drive         <= nxt inside {ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD};
         arbo_if_valid <= (nxt == ST_DONE) && (cur.owner == OWN_IF);
         arbo_mem_done <= (nxt == ST_DONE) && (cur.owner == OWN_MEM);
         if (grant) begin
            cur            <= win;
            arbo_ram2_addr <= win.addr;
         end
         if (capture) begin
            if (cur.owner == OWN_MEM) begin
               arbo_mem_rdata <= arbio_ram2_data;
            end else begin
               arbo_if_data <= arbio_ram2_data;
            end
         end
      end
   end

   assign arbio_ram2_data = drive ? cur.wdata : 16'hzzzz;

   assign arbo_if_stall  = arbi_if_req & ~arbo_if_valid;
   assign arbo_mem_stall = arbi_mem_req & ~arbo_mem_done;

endmodule

// File: tb/tb_ram2_arbiter.sv
// Bench for ram2_arbiter: two timing configurations, each with an SRAM
// model, a transaction-level reference and directed plus random traffic.
module tb_ram2_arbiter;

   logic clk = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic fin [2];

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : cfg
      localparam int RD   = (g == 0) ? 1 : 3;
      localparam int WE   = (g == 0) ? 2 : 1;
      // Hand-derived pulse cycles for these two configurations.
      localparam int RLAT = (g == 0) ? 2 : 4;
      localparam int WLAT = (g == 0) ? 5 : 4;
      localparam int BLAT = (g == 0) ? 5 : 9;

      logic        rst  = 1'b1;
      logic        ifr  = 1'b0;
      logic        memr = 1'b0;
      logic        mwe  = 1'b0;
      logic [15:0] ifa  = '0;
      logic [15:0] ma   = '0;
      logic [15:0] mwd  = '0;
      logic [15:0] ifd, mrd, addr;
      logic        ifv, ifs, md, ms, en, oe, we;
      wire  [15:0] bus;
      logic [15:0] sram [0:65535];
      logic [15:0] refm [0:65535];

      ram2_arbiter #(.RD_CYCLES(RD), .WE_CYCLES(WE)) dut (
         .arbi_clk        (clk),
         .arbi_rst        (rst),
         .arbi_if_req     (ifr),
         .arbi_if_addr    (ifa),
         .arbo_if_data    (ifd),
         .arbo_if_valid   (ifv),
         .arbo_if_stall   (ifs),
         .arbi_mem_req    (memr),
         .arbi_mem_we     (mwe),
         .arbi_mem_addr   (ma),
         .arbi_mem_wdata  (mwd),
         .arbo_mem_rdata  (mrd),
         .arbo_mem_done   (md),
         .arbo_mem_stall  (ms),
         .arbo_ram2_en    (en),
         .arbo_ram2_oe    (oe),
         .arbo_ram2_we    (we),
         .arbo_ram2_addr  (addr),
         .arbio_ram2_data (bus)
      );

      assign bus = (!en && !oe) ? sram[addr] : 16'hzzzz;

      always @(negedge clk) begin
         if (!en && !we) sram[addr] = bus;
      end

      // Transaction-level reference: one access at a time, fixed latency.
      int          cyc = 0;
      int          ts = 0;
      int          tdone = 0;
      logic        alive = 1'b0;
      logic        started = 1'b0;
      logic        tw = 1'b0;
      logic        town = 1'b0;
      logic [15:0] ta, twd, tdata;
      logic [15:0] xaddr = '0;
      logic [15:0] xifd = '0;
      logic [15:0] xmd = '0;
      logic        xen = 1'b1;

      always @(posedge clk) begin : model
         int e;
         e = cyc;
         cyc++;
         if (rst) begin
            alive   = 1'b0;
            started = 1'b1;
            xaddr   = '0;
            xifd    = '0;
            xmd     = '0;
            xen     = 1'b1;
         end else begin
            xen = 1'b0;
            if ((!alive || e > tdone) && (memr || ifr)) begin
               if (memr) begin
                  town = 1'b1; tw = mwe; ta = ma; twd = mwd;
               end else begin
                  town = 1'b0; tw = 1'b0; ta = ifa; twd = '0;
               end
               alive = 1'b1;
               ts    = e;
               tdone = e + (tw ? WE + 3 : RD + 1);
               xaddr = ta;
               tdata = refm[ta];
               if (tw) refm[ta] = twd;
            end
            if (alive && cyc == tdone && !tw) begin
               if (town) xmd = tdata;
               else xifd = tdata;
            end
         end
      end

      always @(negedge clk) begin : compare
         int   c;
         logic rd_win, we_win, drv, xifv, xmdn;
         c = cyc;
         if (started) begin
            rd_win = alive && !tw && c >= ts + 1 && c <= ts + RD;
            we_win = alive && tw && c >= ts + 2 && c <= ts + WE + 1;
            drv    = alive && tw && c >= ts + 1 && c <= ts + WE + 2;
            xifv   = alive && !town && c == tdone;
            xmdn   = alive && town && c == tdone;
            chk("en", en, xen);
            chk("oe", oe, !rd_win);
            chk("we", we, !we_win);
            chk("oe_we_overlap", !oe && !we, 1'b0);
            chk("addr", addr, xaddr);
            chk("if_valid", ifv, xifv);
            chk("mem_done", md, xmdn);
            chk("if_data", ifd, xifd);
            chk("mem_rdata", mrd, xmd);
            chk("if_stall", ifs, ifr && !xifv);
            chk("mem_stall", ms, memr && !xmdn);
            if (drv) chk("bus_wdata", bus, twd);
         end
      end

      task automatic step();
         @(posedge clk);
         #2;
      endtask

      task automatic wait_pulse(input bit want_mem, output int n);
         n = 0;
         do begin
            step();
            n++;
         end while (!(want_mem ? md : ifv) && n < 40);
         if (!(want_mem ? md : ifv)) chk("pulse_timeout", 32'd0, 32'd1);
      endtask

      function automatic logic [15:0] pick();
         return 16'h0200 + 16'($urandom_range(7));
      endfunction

      initial begin : drive
         int n;
         int nm;
         fin[g] = 1'b0;
         for (int i = 0; i < 65536; i++) begin
            sram[i] = 16'(i) ^ 16'hA5C3;
            refm[i] = 16'(i) ^ 16'hA5C3;
         end
         sram[16'h0040] = 16'hBEEF;
         refm[16'h0040] = 16'hBEEF;
         repeat (3) step();
         chk("rst_en", en, 1'b1);
         chk("rst_if_valid", ifv, 1'b0);
         rst = 1'b0;
         step();

         ifr = 1'b1; ifa = 16'h0040;
         wait_pulse(1'b0, n);
         chk("if_rd_lat", n, RLAT);
         chk("if_rd_data", ifd, 16'hBEEF);
         ifr = 1'b0;
         step();

         memr = 1'b1; mwe = 1'b1; ma = 16'h0100; mwd = 16'h1234;
         wait_pulse(1'b1, n);
         chk("mem_wr_lat", n, WLAT);
         memr = 1'b0;
         step();
         chk("sram_wr", sram[16'h0100], 16'h1234);

         ifr = 1'b1; ifa = 16'h0040;
         memr = 1'b1; mwe = 1'b0; ma = 16'h0100;
         n = 0; nm = 0;
         do begin
            step();
            n++;
            if (md && nm == 0) begin
               nm = n;
               memr = 1'b0;
            end
         end while (!ifv && n < 60);
         chk("both_mem_lat", nm, RLAT);
         chk("both_if_lat", n, BLAT);
         chk("both_mem_data", mrd, 16'h1234);
         chk("both_if_data", ifd, 16'hBEEF);
         ifr = 1'b0;
         step();

         memr = 1'b1; mwe = 1'b1; ma = 16'h0300; mwd = 16'hAAAA;
         step();
         step();
         chk("wr_pulse_we", we, 1'b0);
         rst = 1'b1; memr = 1'b0;
         step();
         chk("rst_we", we, 1'b1);
         chk("rst_oe", oe, 1'b1);
         chk("rst_no_done", md, 1'b0);
         rst = 1'b0;
         step();
         step();
         ifr = 1'b1; ifa = 16'h0040;
         wait_pulse(1'b0, n);
         chk("post_rst_lat", n, RLAT);
         chk("post_rst_data", ifd, 16'hBEEF);
         ifr = 1'b0;
         step();

         repeat (1500) begin
            step();
            if (ifr && ifv) ifr = 1'b0;
            else if (!ifr && $urandom_range(2) == 0) begin
               ifr = 1'b1; ifa = pick();
            end
            if (memr && md) memr = 1'b0;
            else if (!memr && $urandom_range(3) == 0) begin
               memr = 1'b1;
               mwe  = 1'($urandom_range(1));
               ma   = pick();
               mwd  = 16'($urandom);
            end
         end
         n = 0;
         while ((ifr || memr) && n < 100) begin
            step();
            n++;
            if (ifr && ifv) ifr = 1'b0;
            if (memr && md) memr = 1'b0;
         end
         chk("drain", {ifr, memr}, 2'b00);
         repeat (3) step();
         fin[g] = 1'b1;
      end
   end

   initial begin : finish_ctl
      int k;
      k = 0;
      while (!(fin[0] === 1'b1 && fin[1] === 1'b1) && k < 20000) begin
         @(posedge clk);
         k++;
      end
      if (!(fin[0] === 1'b1 && fin[1] === 1'b1)) begin
         n_cmp++;
         n_bad++;
         $display("FAIL run_timeout: got unfinished expected finished");
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ram2_arbiter.md
# ram2_arbiter

Sequences the external RAM2 SRAM and shares it between two requesters: instruction fetch (IF, read-only) and the memory stage (MEM, read/write). It owns all RAM2 control strobes, address and tristate data bus, and generates properly spaced OE/WE cycles for the asynchronous SRAM. It returns per-requester completion pulses and stall signals to the pipeline controller. It replaces the ad-hoc combinational RAM2 pause-request path.

## Interface
- RD_CYCLES, 1: cycles OE is held low before read data is captured (1..7).
- WE_CYCLES, 2: cycles WE is held low per write (1..7).
- arbi_clk  in  1  system clock.
- arbi_rst  in  1  synchronous, active-high reset.
- arbi_if_req  in  1  IF read request; held high until arbo_if_valid.
- arbi_if_addr  in  16  IF address; stable while req high.
- arbo_if_data  out  16  fetched word; valid with arbo_if_valid, then held.
- arbo_if_valid  out  1  one-cycle completion pulse.
- arbo_if_stall  out  1  arbi_if_req & ~arbo_if_valid (combinational).
- arbi_mem_req  in  1  MEM request; held high until arbo_mem_done.
- arbi_mem_we  in  1  1 = write, 0 = read; stable while req high.
- arbi_mem_addr  in  16  MEM address.
- arbi_mem_wdata  in  16  write data.
- arbo_mem_rdata  out  16  read data; valid with arbo_mem_done, then held.
- arbo_mem_done  out  1  one-cycle completion pulse.
- arbo_mem_stall  out  1  arbi_mem_req & ~arbo_mem_done (combinational).
- arbo_ram2_en  out  1  chip enable, active low.
- arbo_ram2_oe  out  1  output enable, active low.
- arbo_ram2_we  out  1  write enable, active low.
- arbo_ram2_addr  out  16  SRAM address.
- arbio_ram2_data  inout  16  SRAM data bus.

## Operation
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE: arbitrate. MEM has fixed priority over IF. The winner's address, write flag, data and owner ID are latched. Next state is RD, or WR_SETUP for a MEM write.
- RD: OE=0, address driven, lasting RD_CYCLES cycles. The bus is sampled into the owner's data register on the last RD edge. Next state is DONE.
- WR_SETUP: 1 cycle. Address and data driven, WE=1.
- WR_PULSE: WE=0 for WE_CYCLES cycles. Address and data are held.
- WR_HOLD: 1 cycle. WE=1; address and data are still driven.
- DONE: 1 cycle. The owner's valid/done pulse is high and requests are ignored. Next state is IDLE.
- The data bus is driven only in WR_SETUP, WR_PULSE and WR_HOLD; it is Z otherwise.
- OE=0 and WE=0 are never asserted in the same cycle.
- EN=0 in every state except during reset.
- Duration counter is 3 bits and is loaded on state entry. Parameters outside 1..7 are unsupported.
- A requester drops req in the cycle after its pulse. A req still high in IDLE is treated as a new request.

## Timing
- Reset values (registered outputs): en=1, oe=1, we=1, addr=0, bus Z, if_data=0, mem_rdata=0, if_valid=0, mem_done=0, state IDLE.
- Reset mid-operation: IDLE on the next edge, strobes deasserted and the bus released in the same edge. The in-flight access is lost and no pulse is issued.
- Read latency: req high in IDLE at edge 0 → pulse high during cycle RD_CYCLES+1. Default is 2.
- Write latency: pulse high during cycle WE_CYCLES+3. Default is 5.
- Back-to-back accesses have one IDLE cycle between them. Read throughput is 1 word per RD_CYCLES+2 cycles.
- Simultaneous IF and MEM requests: MEM is served first. IF is served in the IDLE that follows MEM's DONE, unless MEM requests again. Starvation of IF is prevented by the pipeline, since MEM stall freezes IF issue.
- All outputs except the stalls are registered.

## Structure
- Shared defines header holds the state encodings, the owner IDs (OWN_IF, OWN_MEM) and the RD/WE cycle defaults.
- One sub-module, ram2_arb_timer: a 3-bit loadable down-counter with a zero flag, used by the RD and WR_PULSE states.

## Test plan
- Reset, then IF read of 0x0040 with SRAM model holding 0xBEEF → oe=0 for 1 cycle, if_valid pulses in cycle 2, if_data=0xBEEF, bus Z throughout.
- MEM write of 0x1234 to 0x0100 → we=0 for exactly 2 cycles with data stable from setup through hold, mem_done in cycle 5, model holds 0x1234.
- IF and MEM read requested in the same cycle → MEM served first, IF follows after one IDLE cycle; arbo_if_stall stays high until its valid.
- Reset asserted during WR_PULSE → we=1 and bus Z on the next edge, no mem_done pulse, and a new IF read after reset completes normally.
- RD_CYCLES=3, WE_CYCLES=1 → read pulse in cycle 4, write pulse in cycle 4, and oe/we never overlap (checked by assertion).
